// File: rtl/ld_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ld_pkg                                                      |
// | Desc   : Shared types and helpers for the load alignment unit.      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package ld_pkg;

   // RISC-V load funct3 encodings
   typedef enum logic [2:0] {
      LD_LB  = 3'b000,
      LD_LH  = 3'b001,
      LD_LW  = 3'b010,
      LD_LD  = 3'b011,
      LD_LBU = 3'b100,
      LD_LHU = 3'b101,
      LD_LWU = 3'b110,
      LD_BAD = 3'b111
   } ld_sel_e;

   // Control FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD0  = 2'd1,
      ST_RD1  = 2'd2,
      ST_RESP = 2'd3
   } ld_state_e;

   // Access size in bytes; bit 2 (unsigned flag) does not change the size
   function automatic logic [3:0] ld_size(input logic [2:0] sel);
      logic [3:0] sz;
      case (sel[1:0])
         2'b00:   sz = 4'd1;
         2'b01:   sz = 4'd2;
         2'b10:   sz = 4'd4;
         default: sz = 4'd8;
      endcase
      return sz;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ld_align_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ld_align_unit_if                                            |
// | Desc   : Request, memory and response signals of the load unit.     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface ld_align_unit_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [2:0]        req_sel;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rvalid;
   logic [XLEN-1:0]   mem_rdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [XLEN-1:0]   rsp_data;
   logic              rsp_err;

   // Environment side: issues requests, serves memory, consumes responses
   modport master (
      output req_valid, req_addr, req_sel, mem_rvalid, mem_rdata, rsp_ready,
      input  req_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_err
   );

   // Load unit side
   modport slave (
      input  req_valid, req_addr, req_sel, mem_rvalid, mem_rdata, rsp_ready,
      output req_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_err
   );
endinterface
`default_nettype wire

// File: rtl/ld_extract.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ld_extract                                                  |
// | Desc   : Selects the addressed bytes from a two-word window and      |
// |          sign/zero extends them to XLEN.                             |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module ld_extract
   import ld_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int OFFW = $clog2(XLEN / 8)
) (
   input  logic [2*XLEN-1:0] win_i,
   input  logic [OFFW-1:0]   off_i,
   input  logic [2:0]        sel_i,
   output logic [XLEN-1:0]   res_o
);
   logic [XLEN-1:0] shifted;

   // Bring the first addressed byte down to bit 0
   assign shifted = XLEN'(win_i >> {off_i, 3'b000});

   // Trim to access size and extend according to the load type
   always_comb begin
      res_o = shifted;
      case (sel_i)
         LD_LB:   res_o = XLEN'($signed(shifted[7:0]));
         LD_LH:   res_o = XLEN'($signed(shifted[15:0]));
         LD_LW:   res_o = XLEN'($signed(shifted[31:0]));
         LD_LBU:  res_o = XLEN'(shifted[7:0]);
         LD_LHU:  res_o = XLEN'(shifted[15:0]);
         LD_LWU:  res_o = XLEN'(shifted[31:0]);
         default: res_o = shifted;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/ld_align_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ld_align_unit                                               |
// | Desc   : Load unit that reads one or two memory words, aligns and    |
// |          extends the result, and flags illegal/misaligned loads.     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module ld_align_unit
   import ld_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int ADDR_W      = 32,
   parameter bit MISALIGN_EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   ld_align_unit_if.slave bus
);
   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_RD0  = ST_RD0;
   localparam logic [1:0] S_RD1  = ST_RD1;
   localparam logic [1:0] S_RESP = ST_RESP;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        sel_q;
   logic              split_q;
   logic              err_q;
   logic [XLEN-1:0]   lo_q;
   logic [XLEN-1:0]   hi_q;

   logic              accept;
   logic [4:0]        req_end;
   logic              req_split;
   logic              req_bad_sel;
   logic              req_illegal;
   logic [ADDR_W-1:0] base;
   logic [XLEN-1:0]   ext;

   // Request decode: a load spills into the next word when it runs past the word end
   assign accept      = bus.req_valid && (state_q == S_IDLE);
   assign req_end     = 5'(bus.req_addr[OFFW-1:0]) + 5'(ld_size(bus.req_sel));
   assign req_split   = req_end > 5'(NB);
   assign req_bad_sel = (bus.req_sel == LD_BAD) ||
                        ((XLEN == 32) && ((bus.req_sel == LD_LD) || (bus.req_sel == LD_LWU)));
   assign req_illegal = req_bad_sel || (req_split && !MISALIGN_EN);

   assign base = {addr_q[ADDR_W-1:OFFW], OFFW'(0)};

   // Next-state selection
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = req_illegal ? S_RESP : S_RD0;
         S_RD0:   if (bus.mem_rvalid) state_d = split_q ? S_RD1 : S_RESP;
         S_RD1:   if (bus.mem_rvalid) state_d = S_RESP;
         default: if (bus.rsp_ready) state_d = S_IDLE;
      endcase
   end

   // State, request capture and memory word capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         sel_q   <= '0;
         split_q <= 1'b0;
         err_q   <= 1'b0;
         lo_q    <= '0;
         hi_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q  <= bus.req_addr;
            sel_q   <= bus.req_sel;
            split_q <= req_split;
            err_q   <= req_illegal;
            lo_q    <= '0;
            hi_q    <= '0;
         end
         if ((state_q == S_RD0) && bus.mem_rvalid) lo_q <= bus.mem_rdata;
         if ((state_q == S_RD1) && bus.mem_rvalid) hi_q <= bus.mem_rdata;
      end
   end

   ld_extract #(
      .XLEN (XLEN),
      .OFFW (OFFW)
   ) u_extract (
      .win_i ({hi_q, lo_q}),
      .off_i (addr_q[OFFW-1:0]),
      .sel_i (sel_q),
      .res_o (ext)
   );

   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.mem_req   = (state_q == S_RD0) || (state_q == S_RD1);
   assign bus.mem_addr  = (state_q == S_RD0) ? base :
                          (state_q == S_RD1) ? base + ADDR_W'(NB) : '0;
   assign bus.rsp_valid = (state_q == S_RESP);
   assign bus.rsp_err   = (state_q == S_RESP) && err_q;
   // Error responses carry zero data
   assign bus.rsp_data  = ((state_q == S_RESP) && !err_q) ? ext : '0;
endmodule
`default_nettype wire
